// File: rtl/count1k_pkg.sv
// rtl/count1k_pkg.sv - shared constants, state encoding and sequence helper for the count monitor
package count1k_pkg;

  localparam int C1K_WIDTH   = 10;
  localparam int C1K_MODULUS = 1000;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Successor of v in a wrap-at-(modulus-1) sequence.
  function automatic int unsigned nxt(input int unsigned v, input int unsigned modulus);
    return (v == modulus - 1) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/count1k_monitor_if.sv
// rtl/count1k_monitor_if.sv - counter bus: sample strobe plus count value
interface count1k_if #(
  parameter int WIDTH = 10
);
  logic             q_valid;
  logic [WIDTH-1:0] q;

  modport master (output q_valid, output q);
  modport slave  (input  q_valid, input  q);
endinterface

// File: rtl/count1k_monitor_sat_counter.sv
// rtl/count1k_monitor_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  // Count events, holding once the maximum value is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/count1k_monitor.sv
// rtl/count1k_monitor.sv - lock/track checker for the mod-1000 count stream
module count1k_monitor
  import count1k_pkg::*;
#(
  parameter int WIDTH       = C1K_WIDTH,
  parameter int MODULUS     = C1K_MODULUS,
  parameter int LOCK_CNT    = 4,
  parameter int STAT_W      = 16,
  parameter int ZERO_RESYNC = 1
) (
  input  logic              clk,
  input  logic              reset,
  count1k_if.slave          bus,
  output logic              locked,
  output logic              err_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  state_t           state_q;
  logic [MW-1:0]    match_q;
  logic [WIDTH-1:0] expected_q;
  logic             locked_q;
  logic             err_pulse_q;

  logic             legal;
  logic             hit;
  logic             resync;
  logic             err_inc;
  logic             wrap_inc;
  logic [WIDTH-1:0] nxt_v;
  logic [MW-1:0]    match_d;

  // Classify the current sample against the tracked sequence.
  always_comb begin
    legal    = (32'(bus.q) < 32'(MODULUS));
    hit      = (bus.q == expected_q);
    nxt_v    = WIDTH'(nxt(32'(bus.q), 32'(MODULUS)));
    match_d  = match_q + MW'(1);
    resync   = (ZERO_RESYNC != 0) && (bus.q == '0) && !hit;
    err_inc  = bus.q_valid && (state_q == ST_LOCKED) && !hit && !resync;
    wrap_inc = bus.q_valid && (state_q == ST_LOCKED) && hit && (bus.q == '0);
  end

  // Lock FSM with tracked expectation, match run length and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      match_q     <= '0;
      expected_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= err_inc;
      if (bus.q_valid) begin
        case (state_q)
          ST_UNLOCKED: begin
            if (legal) begin
              expected_q <= nxt_v;
              match_q    <= MW'(1);
              state_q    <= ST_LOCKING;
            end
          end
          ST_LOCKING: begin
            if (!legal) begin
              match_q <= '0;
              state_q <= ST_UNLOCKED;
            end else if (hit) begin
              expected_q <= nxt_v;
              match_q    <= match_d;
              if (match_d == MW'(LOCK_CNT)) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              expected_q <= nxt_v;
              match_q    <= MW'(1);
            end
          end
          ST_LOCKED: begin
            if (hit) begin
              expected_q <= nxt_v;
            end else if (legal) begin
              // Zero resync and ordinary legal mismatches both restart locking from q.
              expected_q <= nxt_v;
              match_q    <= MW'(1);
              state_q    <= ST_LOCKING;
              locked_q   <= 1'b0;
            end else begin
              match_q  <= '0;
              state_q  <= ST_UNLOCKED;
              locked_q <= 1'b0;
            end
          end
          default: begin
            match_q  <= '0;
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .value (err_count)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_inc),
    .value (wrap_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule
